vga_pattern_ram_arbiter: RTL

- Shares one single-port 16-word x 16-bit pattern RAM between two clients: the VGA display fetch path and a host that reads and writes over request/acknowledge handshakes.
- The display client loads one pattern word per scanline, during horizontal blanking, into a line buffer. From that buffer the block produces a scaled 16x16 monochrome pixel stream.
- The block sits between the 800x600@60 sync generator (vga_clk, 40 MHz) and the RAM.

---
 rtl/vga_pattern_ram_arbiter_pkg.sv | 25 ++
 rtl/vga_pattern_ram_arbiter_if.sv | 40 ++++
 rtl/vga_edge_detect.sv | 20 ++
 rtl/vga_pattern_ram_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/vga_pattern_ram_arbiter_pkg.sv
// rtl/vga_pattern_ram_arbiter_pkg.sv - shared types and constants for the pattern RAM arbiter
package vga_pattern_ram_arbiter_pkg;

    localparam int PAT_DW = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        FETCH_LAT = 3'd2,
        WR        = 3'd3,
        RD        = 3'd4,
        RD_LAT    = 3'd5
    } arb_state_t;

    typedef enum logic {
        CL_WR = 1'b0,
        CL_RD = 1'b1
    } client_t;

    // Pattern extent in screen pixels, both horizontally and vertically.
    function automatic int win_size(input int shift);
        return PAT_DW << shift;
    endfunction

endpackage

// File: rtl/vga_pattern_ram_arbiter_if.sv
// rtl/vga_pattern_ram_arbiter_if.sv - host request/ack handshakes plus the single-port RAM bus
interface vga_pattern_ram_arbiter_if
    import vga_pattern_ram_arbiter_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = PAT_DW
) ();

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    modport slave (
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata,
        input  wr_req, wr_addr, wr_data,
        output wr_ack,
        input  rd_req, rd_addr,
        output rd_data, rd_valid
    );

    modport master (
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata,
        output wr_req, wr_addr, wr_data,
        input  wr_ack,
        output rd_req, rd_addr,
        input  rd_data, rd_valid
    );

endinterface

// File: rtl/vga_edge_detect.sv
// rtl/vga_edge_detect.sv - registered rise/fall detector for a sync-generator flag
module vga_edge_detect (
    input  logic vga_clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    always_ff @(posedge vga_clk) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig;
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/vga_pattern_ram_arbiter.sv
// rtl/vga_pattern_ram_arbiter.sv - shares the pattern RAM between per-line display fetch and a host
module vga_pattern_ram_arbiter
    import vga_pattern_ram_arbiter_pkg::*;
#(
    parameter int SHIFT = 2,
    parameter int AW    = 4,
    parameter int DW    = PAT_DW
) (
    input  logic                      vga_clk,
    input  logic                      rst,
    input  logic                      ready_sig,
    input  logic                      frame_sig,
    input  logic [10:0]               column_addr,
    vga_pattern_ram_arbiter_if.slave  bus,
    output logic                      pix_on
);

    localparam int          IW  = $clog2(DW);
    localparam logic [10:0] WIN = 11'(win_size(SHIFT));

    arb_state_t    state_q, state_d;
    client_t       rr_q, rr_d;
    logic [10:0]   line_cnt, line_nxt;
    logic [DW-1:0] line_buf, line_buf_d;
    logic          fetch_pend, fetch_pend_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d, rd_data_q, rd_data_d;
    logic          ram_we_q, ram_we_d, wr_ack_q, wr_ack_d, rd_valid_q, rd_valid_d;
    logic          frame_rise, frame_fall, ready_rise, ready_fall;
    logic          trigger, in_win_nxt, rd_go, grant_wr, grant_rd;
    logic [AW-1:0] fetch_idx;
    logic [IW-1:0] col_idx;
    logic          unused_edges;

    vga_edge_detect u_frame_edge (
        .vga_clk (vga_clk), .rst (rst), .sig (frame_sig), .rise (frame_rise), .fall (frame_fall)
    );
    vga_edge_detect u_ready_edge (
        .vga_clk (vga_clk), .rst (rst), .sig (ready_sig), .rise (ready_rise), .fall (ready_fall)
    );
    assign unused_edges = frame_fall ^ ready_rise;

    assign trigger = frame_rise | ready_fall;

    always_comb begin
        line_nxt = line_cnt;
        if (frame_rise)                            line_nxt = '0;
        else if (ready_fall && line_cnt != 11'h7FF) line_nxt = line_cnt + 11'd1;
    end

    // The fetch decision uses the count this edge will produce, so a trigger is acted on at once.
    assign in_win_nxt = (line_nxt < WIN);
    assign fetch_idx  = AW'(line_nxt >> SHIFT);
    // rd_valid trails RD_LAT by a cycle; masking keeps a still-held rd_req from being re-granted.
    assign rd_go      = bus.rd_req & ~rd_valid_q;

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        line_buf_d   = line_buf;
        fetch_pend_d = fetch_pend | trigger;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_we_d     = 1'b0;
        wr_ack_d     = 1'b0;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        grant_wr     = 1'b0;
        grant_rd     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_pend | trigger) begin
                    if (in_win_nxt) begin
                        state_d    = FETCH;
                        ram_addr_d = fetch_idx;
                    end else begin
                        line_buf_d   = '0;
                        fetch_pend_d = 1'b0;
                    end
                end else if (bus.wr_req && rd_go) begin
                    grant_wr = (rr_q == CL_RD);
                    grant_rd = (rr_q == CL_WR);
                end else begin
                    grant_wr = bus.wr_req;
                    grant_rd = rd_go;
                end
                if (grant_wr) begin
                    state_d     = WR;
                    ram_addr_d  = bus.wr_addr;
                    ram_wdata_d = bus.wr_data;
                    ram_we_d    = 1'b1;
                    wr_ack_d    = 1'b1;
                end else if (grant_rd) begin
                    state_d    = RD;
                    ram_addr_d = bus.rd_addr;
                end
            end
            FETCH:     state_d = FETCH_LAT;
            FETCH_LAT: begin
                line_buf_d   = bus.ram_rdata;
                fetch_pend_d = trigger;
                state_d      = IDLE;
            end
            WR: begin
                rr_d    = CL_WR;
                state_d = IDLE;
            end
            RD:        state_d = RD_LAT;
            RD_LAT: begin
                rd_data_d  = bus.ram_rdata;
                rd_valid_d = 1'b1;
                rr_d       = CL_RD;
                state_d    = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    assign col_idx = IW'(column_addr >> SHIFT);

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= CL_RD;
            line_cnt    <= '0;
            line_buf    <= '0;
            fetch_pend  <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            pix_on      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            line_cnt    <= line_nxt;
            line_buf    <= line_buf_d;
            fetch_pend  <= fetch_pend_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            wr_ack_q    <= wr_ack_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            pix_on      <= ready_sig && (line_cnt < WIN) && (column_addr < WIN)
                           && line_buf[IW'(DW-1) - col_idx];
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.wr_ack    = wr_ack_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;

endmodule
